// File: rtl/capture_dump.sv
// capture_dump: trigger-qualified circular sample capture with a byte-stream dump port.
// Define TRIG_EDGE_EN to trigger on a rising match instead of a match level.
module capture_dump #(
   parameter int DATA_W     = 8,
   parameter int TRIG_W     = 4,
   parameter int DEPTH_LOG2 = 10,
   parameter int PRE_TRIG   = 16
) (
   input  logic              clkin,
   input  logic              rst_n,
   input  logic              arm,
   input  logic              abort,
   input  logic [DATA_W-1:0] data_in,
   input  logic [TRIG_W-1:0] trig_in,
   input  logic [TRIG_W-1:0] trig_mask,
   input  logic [TRIG_W-1:0] trig_value,
   output logic              busy,
   output logic              triggered,
   output logic [7:0]        m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last
);

   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int BYTES  = DATA_W / 8;
   localparam int BW     = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int DL1    = DEPTH_LOG2 + 1;
   localparam int POST_N = DEPTH - PRE_TRIG - 1;

   localparam logic [DEPTH_LOG2-1:0] PRE_LAST  = DEPTH_LOG2'(PRE_TRIG == 0 ? 0 : PRE_TRIG - 1);
   localparam logic [DEPTH_LOG2-1:0] POST_LAST = DEPTH_LOG2'(POST_N == 0 ? 0 : POST_N - 1);
   localparam logic [BW-1:0]         BYTE_LAST = BW'(BYTES - 1);
   localparam logic [DL1-1:0]        DEPTH_CNT = DL1'(DEPTH);
   localparam logic [DL1-1:0]        LAST_IDX  = DL1'(DEPTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DUMP} state_t;

   state_t state, next_state;

   logic [DATA_W-1:0]     mem [DEPTH];
   logic [DATA_W-1:0]     rd_data;
   logic [DATA_W-1:0]     buf_word;
   logic [DATA_W-1:0]     out_word;
   logic [DATA_W-1:0]     src_word;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] wr_ptr_inc;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2-1:0] cnt;
   logic [DL1-1:0]        issued_cnt;
   logic [DL1-1:0]        loaded_cnt;
   logic [BW-1:0]         byte_idx;
   logic                  buf_valid;
   logic                  fetch_pending;
   logic                  last_word;
   logic                  match;
   logic                  fire;
   logic                  we;
   logic                  accept;
   logic                  word_done;
   logic                  load;
   logic                  held_after;
   logic                  issue;

   assign match      = ((trig_in ^ trig_value) & trig_mask) == '0;
   assign wr_ptr_inc = wr_ptr + 1'b1;

`ifdef TRIG_EDGE_EN
   logic match_q;

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) match_q <= 1'b0;
      else        match_q <= match;
   end

   assign fire = match & ~match_q;
`else
   assign fire = match;
`endif

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (abort) begin
         next_state = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: if (arm) next_state = (PRE_TRIG == 0) ? S_WAIT : S_PRE;
            S_PRE:  if (cnt == PRE_LAST) next_state = S_WAIT;
            S_WAIT: if (fire) next_state = (POST_N == 0) ? S_DUMP : S_POST;
            S_POST: if (cnt == POST_LAST) next_state = S_DUMP;
            S_DUMP: if (accept && m_last) next_state = S_IDLE;
            default: next_state = S_IDLE;
         endcase
      end
   end

   // At most one word is in flight beyond the output register: a read is issued
   // only when nothing would be left waiting after this cycle's load.
   always_comb begin
      we         = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
      accept     = m_valid && m_ready;
      word_done  = accept && (byte_idx == BYTE_LAST);
      load       = (state == S_DUMP) && (!m_valid || word_done) && (buf_valid || fetch_pending);
      src_word   = buf_valid ? buf_word : rd_data;
      held_after = (buf_valid || fetch_pending) && !load;
      issue      = (state == S_DUMP) && !abort && (issued_cnt != DEPTH_CNT) && !held_after;
   end

   always_ff @(posedge clkin) begin
      if (we)    mem[wr_ptr] <= data_in;
      if (issue) rd_data <= mem[rd_ptr];
   end

   // After the final post-trigger write, wr_ptr points at the oldest window sample.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         cnt           <= '0;
         issued_cnt    <= '0;
         loaded_cnt    <= '0;
         byte_idx      <= '0;
         buf_word      <= '0;
         out_word      <= '0;
         buf_valid     <= 1'b0;
         fetch_pending <= 1'b0;
         last_word     <= 1'b0;
         m_valid       <= 1'b0;
         triggered     <= 1'b0;
      end else if (next_state == S_IDLE) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         cnt           <= '0;
         issued_cnt    <= '0;
         loaded_cnt    <= '0;
         byte_idx      <= '0;
         buf_word      <= '0;
         out_word      <= '0;
         buf_valid     <= 1'b0;
         fetch_pending <= 1'b0;
         last_word     <= 1'b0;
         m_valid       <= 1'b0;
         triggered     <= 1'b0;
      end else begin
         case (state)
            S_PRE, S_WAIT, S_POST: begin
               wr_ptr <= wr_ptr_inc;
               cnt    <= (next_state != state) ? '0 : cnt + 1'b1;
               if (state == S_WAIT && next_state != S_WAIT) triggered <= 1'b1;
               if (next_state == S_DUMP) rd_ptr <= wr_ptr_inc;
            end
            S_DUMP: begin
               if (issue) begin
                  rd_ptr     <= rd_ptr + 1'b1;
                  issued_cnt <= issued_cnt + 1'b1;
               end
               fetch_pending <= issue;
               if (fetch_pending && !load) begin
                  buf_word  <= rd_data;
                  buf_valid <= 1'b1;
               end else if (load) begin
                  buf_valid <= 1'b0;
               end
               if (load) begin
                  out_word   <= src_word;
                  m_valid    <= 1'b1;
                  byte_idx   <= '0;
                  last_word  <= (loaded_cnt == LAST_IDX);
                  loaded_cnt <= loaded_cnt + 1'b1;
               end else if (word_done) begin
                  m_valid <= 1'b0;
               end else if (accept) begin
                  byte_idx <= byte_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      m_data = out_word[7:0];
      for (int i = 0; i < BYTES; i++) begin
         if (byte_idx == BW'(i)) m_data = out_word[8*i +: 8];
      end
   end

   assign busy   = (state != S_IDLE);
   assign m_last = m_valid && last_word && (byte_idx == BYTE_LAST);

endmodule
